// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM states, framing constants and the CRC-8 byte step for uart_frame_tx
package uart_frame_pkg;
  typedef enum logic [2:0] {IDLE, SOF, LEN, PAYLOAD, CHECK} state_t;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? (c << 1) ^ CRC8_POLY : c << 1;
    return c;
  endfunction
endpackage

// File: rtl/frame_checksum.sv
// frame_checksum: running frame check byte; XOR fold by default, CRC-8 (poly 0x07) when FRAME_CRC8_EN is defined
module frame_checksum
  import uart_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] sum
);
  logic [7:0] sum_q, sum_d, fold;
`ifdef FRAME_CRC8_EN
  assign fold = crc8_byte(sum_q, data);
`else
  assign fold = sum_q ^ data;
`endif
  always_comb sum_d = clr ? 8'h00 : en ? fold : sum_q;
  always_ff @(posedge clk) sum_q <= !rst ? 8'h00 : sum_d;
  assign sum = sum_q;
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: frames a message word as SOF, LEN, payload (MSB-first), check byte onto a valid/ready byte stream
// FRAME_CRC8_EN selects a CRC-8 check byte instead of XOR.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4,
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PAYLOAD_BYTES*8-1:0] msg_data,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid,
  input  logic                       byte_ready,
  output logic                       busy,
  output logic [CNT_W-1:0]           frames_sent
);
  localparam int PW = PAYLOAD_BYTES * 8;
  localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_BYTES);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);
  state_t state_q, state_d;
  logic [PW-1:0] shift_q, shift_d;
  logic [7:0] idx_q, idx_d, csum;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic accept, xfer;
  assign accept = msg_valid && msg_ready;
  assign xfer = byte_valid && byte_ready;
  always_ff @(posedge clk) begin
    state_q <= !rst ? IDLE : state_d;
    shift_q <= !rst ? '0 : shift_d;
    idx_q <= !rst ? 8'h00 : idx_d;
    frames_q <= !rst ? '0 : frames_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? SOF : IDLE;
      SOF:     state_d = xfer ? LEN : SOF;
      LEN:     state_d = xfer ? PAYLOAD : LEN;
      PAYLOAD: state_d = (xfer && idx_q == LAST_IDX) ? CHECK : PAYLOAD;
      CHECK:   state_d = xfer ? IDLE : CHECK;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    shift_d = accept ? msg_data : (state_q == PAYLOAD && xfer) ? shift_q << 8 : shift_q;
    idx_d = accept ? 8'h00 : (state_q == PAYLOAD && xfer) ? idx_q + 8'd1 : idx_q;
    frames_d = (state_q == CHECK && xfer) ? frames_q + CNT_W'(1) : frames_q;
  end
  always_comb begin
    msg_ready = state_q == IDLE;
    byte_valid = state_q != IDLE;
    busy = state_q != IDLE;
    byte_out = state_q == SOF     ? SOF_BYTE :
               state_q == LEN     ? LEN_BYTE :
               state_q == PAYLOAD ? shift_q[PW-1 -: 8] :
               state_q == CHECK   ? csum : 8'h00;
  end
  frame_checksum u_csum (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (xfer && (state_q == LEN || state_q == PAYLOAD)),
    .data(byte_out),
    .sum (csum)
  );
  assign frames_sent = frames_q;
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Upstream framer for the FPGA-to-NANO UART link. It accepts one fixed-width message word per handshake and emits it as a byte stream: start-of-frame byte, length byte, payload bytes sent MSB-first, then a checksum byte. The byte stream drives the byte-level UART transmitter through a valid/ready handshake, so the transmitter's idle/ready output backpressures the framer directly.

Parameters:
PAYLOAD_BYTES, 4, number of payload bytes per frame; legal range 1..255.
SOF_BYTE, 8'hA5, start-of-frame marker byte.
CNT_W, 16, width of the frames_sent counter.

Ports:
clk  in  1  system clock (50 MHz).
rst  in  1  synchronous active-low reset.
msg_data  in  PAYLOAD_BYTES*8  message word to frame.
msg_valid  in  1  msg_data is valid.
msg_ready  out  1  framer can accept a message (high only in IDLE).
byte_out  out  8  current frame byte, to the UART transmitter data input.
byte_valid  out  1  byte_out is valid, to the transmitter valid input.
byte_ready  in  1  transmitter ready output.
busy  out  1  high whenever state != IDLE.
frames_sent  out  CNT_W  count of fully transferred frames.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-low.
- Reset values: state=IDLE, msg_ready=1, byte_valid=0, byte_out=0, busy=0, frames_sent=0, checksum=0, byte index=0.
- Handshakes: a message is accepted on msg_valid&&msg_ready. A byte is transferred on byte_valid&&byte_ready.
- States:
  - IDLE: msg_ready=1, byte_valid=0. On accept, latch msg_data into the shift register, clear the checksum and byte index, and go to SOF.
  - SOF: byte_out=SOF_BYTE. On transfer, go to LEN.
  - LEN: byte_out=PAYLOAD_BYTES[7:0]. On transfer, fold the byte into the checksum and go to PAYLOAD.
  - PAYLOAD: byte_out=shift[top byte]. On transfer, fold the byte into the checksum, shift left 8, and increment the index. When index==PAYLOAD_BYTES-1 and a transfer occurs, go to CHECK.
  - CHECK: byte_out=checksum. On transfer, frames_sent++ (wraps modulo 2^CNT_W) and go to IDLE.
- Outputs: byte_valid=1 in SOF, LEN, PAYLOAD and CHECK. byte_out and byte_valid are decoded from registered state, so they must stay stable while byte_ready=0.
- Latency: SOF is presented on the cycle after message accept. With byte_ready held high, there is one byte per cycle and no bubbles. A new message can be accepted on the cycle after the CHECK transfer; no back-to-back accept in the same cycle.
- Checksum: XOR of the LEN byte and all payload bytes. The SOF byte is excluded.
- Boundaries:
  - msg_valid while busy is ignored; the message is not latched.
  - The message word is captured once; later changes to msg_data do not affect an in-flight frame.
  - byte_ready low for N cycles holds the state and byte_out for N cycles.
  - PAYLOAD_BYTES=1 means PAYLOAD lasts exactly one transfer.
  - Reset mid-frame returns to IDLE and drops byte_valid the next cycle. No partial-frame recovery is attempted; frames_sent is cleared.

Optional Feature:
- Macro: FRAME_CRC8_EN.
- Defined: the checksum byte is CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over LEN and the payload bytes in transmit order, one byte per transfer cycle.
- Undefined: XOR checksum as above.
- Frame length and timing are identical in both cases.

Decomposition:
- Package uart_frame_pkg holds:
  - the state enum (IDLE, SOF, LEN, PAYLOAD, CHECK);
  - the default SOF constant 8'hA5;
  - the CRC8 polynomial constant 8'h07;
  - a crc8_byte function (8 unrolled shift/xor steps).
- One sub-module: frame_checksum, with clear, byte-enable and 8-bit data inputs and an 8-bit accumulated result. It selects XOR or CRC-8 internally under FRAME_CRC8_EN.

Test Plan:
- Basic frame: PAYLOAD_BYTES=4, msg_data=32'h11223344, byte_ready=1 -> bytes A5,04,11,22,33,44,40 on 7 consecutive cycles; frames_sent=1; msg_ready high the cycle after the 40 transfer.
- Backpressure: same message, byte_ready low for 5 cycles during the 22 byte -> byte_out holds 22 and byte_valid stays high for 5 cycles; byte order and checksum unchanged.
- Busy ignore: assert msg_valid with 32'hDEADBEEF during the frame above -> not accepted, msg_ready=0 throughout, transmitted bytes unchanged.
- Mid-frame reset: drop rst for 1 cycle while the 33 byte is presented -> next cycle state IDLE, byte_valid=0, frames_sent=0; a following message 32'h01020304 yields A5,04,01,02,03,04,00.
- CRC option: build with FRAME_CRC8_EN, PAYLOAD_BYTES=1, msg_data=8'h00 -> bytes A5,01,00,15.
- Counter wrap: CNT_W=2, send 5 frames -> frames_sent sequence 1,2,3,0,1.
